mp_link: RTL and testbench

- Bidirectional serial link between two Duck Hunt boards. It replaces the parallel multiplayer wires with one TX line and one RX line.
- Serializes local {reload, pause, score[3:0]} into framed packets and deserializes the peer's packets into remote_* signals.
- Connects directly to the game core's multiplayer outputs and debounced player2 inputs.
- Produces remote_connected, which drives the reload/pause arbitration.

---
 rtl/mp_link.sv | 228 ++++++++++++++++++++++
 tb/tb_mp_link.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mp_link.sv
// Serial multiplayer link: continuously frames the local reload/pause/score onto tx_line
// and decodes the peer's frames from rx_line into remote_* with a link-alive timeout.
module mp_link #(
  parameter int BIT_CYCLES     = 6500,
  parameter int GAP_BITS       = 2,
  parameter int TIMEOUT_CYCLES = 650000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       local_reload,
  input  logic       local_pause,
  input  logic [3:0] local_score,
  output logic       tx_line,
  input  logic       rx_line,
  output logic       remote_reload,
  output logic       remote_pause,
  output logic [3:0] remote_score,
  output logic       remote_connected,
  output logic       frame_error
);

  localparam int BC_W  = $clog2(BIT_CYCLES) + 1;
  localparam int GAP_W = $clog2(GAP_BITS) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(BIT_CYCLES - 1);
  localparam logic [BC_W-1:0]  HALF_LAST = BC_W'(BIT_CYCLES / 2 - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_BITS - 1);
  localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    TX_GAP,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  tx_state_t        tx_state;
  tx_state_t        tx_next;
  logic [BC_W-1:0]  tx_cnt;
  logic [GAP_W-1:0] tx_gap;
  logic [2:0]       tx_idx;
  logic [5:0]       tx_data;
  logic             tx_tick;

  assign tx_tick = (tx_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_GAP;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_GAP:    if (tx_tick && tx_gap == GAP_LAST) tx_next = TX_START;
      TX_START:  if (tx_tick) tx_next = TX_DATA;
      TX_DATA:   if (tx_tick && tx_idx == 3'd5) tx_next = TX_PARITY;
      TX_PARITY: if (tx_tick) tx_next = TX_STOP;
      TX_STOP:   if (tx_tick) tx_next = TX_GAP;
      default:   tx_next = TX_GAP;
    endcase
  end

  // tx_line is loaded on the same edge that moves the FSM into each bit,
  // so every bit is held for exactly BIT_CYCLES clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt  <= '0;
      tx_gap  <= '0;
      tx_idx  <= '0;
      tx_data <= '0;
      tx_line <= 1'b1;
    end else begin
      tx_cnt <= tx_tick ? '0 : tx_cnt + BC_W'(1);
      if (tx_tick) begin
        case (tx_state)
          TX_GAP: begin
            if (tx_gap == GAP_LAST) begin
              tx_gap  <= '0;
              tx_data <= {local_score, local_pause, local_reload};
              tx_line <= 1'b0;
            end else begin
              tx_gap <= tx_gap + GAP_W'(1);
            end
          end
          TX_START: begin
            tx_idx  <= '0;
            tx_line <= tx_data[0];
          end
          TX_DATA: begin
            if (tx_idx == 3'd5) begin
              tx_line <= ^tx_data;
            end else begin
              tx_idx  <= tx_idx + 3'd1;
              tx_line <= tx_data[tx_idx + 3'd1];
            end
          end
          default: tx_line <= 1'b1;
        endcase
      end
    end
  end

  rx_state_t       rx_state;
  rx_state_t       rx_next;
  logic            rx_meta;
  logic            rx_sync;
  logic            rx_prev;
  logic [BC_W-1:0] rx_cnt;
  logic [2:0]      rx_idx;
  logic [5:0]      rx_shift;
  logic            rx_par;
  logic            rx_fall;
  logic            rx_sample;
  logic            frame_good;
  logic            frame_bad;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_next;

  // Synchronizer resets high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_line;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall   = rx_prev & ~rx_sync;
  assign rx_sample = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next    = rx_state;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (rx_state)
      RX_IDLE:   if (rx_fall) rx_next = RX_START;
      RX_START:  if (rx_sample) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_sample && rx_idx == 3'd5) rx_next = RX_PARITY;
      RX_PARITY: if (rx_sample) rx_next = RX_STOP;
      RX_STOP: begin
        if (rx_sample) begin
          rx_next = RX_IDLE;
          if (rx_sync && (rx_par == ^rx_shift)) frame_good = 1'b1;
          else                                  frame_bad  = 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // The bit counter restarts at every sample point, so later samples land
  // a whole bit after the mid-start sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
    end else begin
      rx_cnt <= (rx_state == RX_IDLE || rx_sample) ? '0 : rx_cnt + BC_W'(1);
      if (rx_sample) begin
        case (rx_state)
          RX_START: rx_idx <= '0;
          RX_DATA: begin
            rx_shift <= {rx_sync, rx_shift[5:1]};
            rx_idx   <= rx_idx + 3'd1;
          end
          RX_PARITY: rx_par <= rx_sync;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    to_next = to_cnt;
    if (frame_good)         to_next = TO_LOAD;
    else if (to_cnt != '0)  to_next = to_cnt - TO_W'(1);
  end

  // A good frame takes priority over expiry; on expiry the remote requests
  // are dropped so a vanished peer cannot keep the game paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt           <= TO_LOAD;
      remote_connected <= 1'b0;
      remote_reload    <= 1'b0;
      remote_pause     <= 1'b0;
      remote_score     <= 4'd0;
      frame_error      <= 1'b0;
    end else begin
      to_cnt      <= to_next;
      frame_error <= frame_bad;
      if (frame_good) begin
        remote_connected <= 1'b1;
        remote_reload    <= rx_shift[0];
        remote_pause     <= rx_shift[1];
        remote_score     <= rx_shift[5:2];
      end else if (to_next == '0) begin
        remote_connected <= 1'b0;
        remote_reload    <= 1'b0;
        remote_pause     <= 1'b0;
        remote_score     <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_mp_link.sv
// Directed bench for mp_link: TX waveform, loopback, parity error, false start,
// timeout and mid-frame reset, with a queue of expected remote words.
module tb_mp_link;

  localparam int BC = 8;
  localparam int GB = 2;
  localparam int TO = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       local_reload;
  logic       local_pause;
  logic [3:0] local_score;
  logic       tx_line;
  logic       rx_line;
  logic       remote_reload;
  logic       remote_pause;
  logic [3:0] remote_score;
  logic       remote_connected;
  logic       frame_error;

  logic loop_en;
  logic rx_drv;

  assign rx_line = loop_en ? tx_line : rx_drv;

  always #5 clk = ~clk;

  mp_link #(
    .BIT_CYCLES(BC),
    .GAP_BITS(GB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .local_reload(local_reload),
    .local_pause(local_pause),
    .local_score(local_score),
    .tx_line(tx_line),
    .rx_line(rx_line),
    .remote_reload(remote_reload),
    .remote_pause(remote_pause),
    .remote_score(remote_score),
    .remote_connected(remote_connected),
    .frame_error(frame_error)
  );

  int checks   = 0;
  int failures = 0;
  int fe_count = 0;
  logic [5:0] exp_q[$];

  always @(negedge clk) if (frame_error === 1'b1) fe_count++;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the next expected word from the scoreboard and compare it with remote_*.
  task automatic check_remote(input string tag);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      check_output({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_output({tag, "_score"},  remote_score,  e[5:2]);
      check_output({tag, "_pause"},  remote_pause,  e[1]);
      check_output({tag, "_reload"}, remote_reload, e[0]);
    end
  endtask

  // Bit-bang a frame onto rx for ncyc cycles; upd_k is the first cycle index
  // at which remote_* equals d, or -1.
  task automatic apply_stimulus(input logic [5:0] d, input logic par, input logic stp,
                                input int ncyc, output int upd_k);
    logic [8:0] bits;
    bits  = {stp, par, d, 1'b0};
    upd_k = -1;
    for (int i = 0; i < ncyc; i++) begin
      rx_drv = bits[i / BC];
      tick();
      if (upd_k < 0 && {remote_score, remote_pause, remote_reload} === d) upd_k = i;
    end
  endtask

  initial begin
    int k;
    int upd;
    int fe0;
    logic [5:0] d;
    logic [8:0] wf;
    logic wexp;

    rst = 1'b1;
    loop_en = 1'b0;
    rx_drv = 1'b1;
    local_reload = 1'b0;
    local_pause = 1'b0;
    local_score = 4'd0;
    repeat (3) tick();
    check_output("rst_tx_line", tx_line, 1'b1);
    check_output("rst_connected", remote_connected, 1'b0);
    check_output("rst_remote", {remote_score, remote_pause, remote_reload}, 6'd0);
    check_output("rst_frame_error", frame_error, 1'b0);

    // TX waveform for data 6'b101101
    d = 6'b101101;
    {local_score, local_pause, local_reload} = d;
    tick();
    rst = 1'b0;
    k = 0;
    while (tx_line !== 1'b0 && k < 40) begin
      tick();
      k++;
    end
    check_output("tx_first_gap_cycles", k, 16);
    wf = {1'b1, ^d, d, 1'b0};
    for (int j = 1; j <= 88; j++) begin
      tick();
      if (j < 72)      wexp = wf[j / BC];
      else if (j < 88) wexp = 1'b1;
      else             wexp = 1'b0;
      check_output($sformatf("tx_wave_c%0d", j), tx_line, wexp);
    end

    // Loopback
    rst = 1'b1;
    loop_en = 1'b1;
    local_score = 4'hA;
    local_pause = 1'b1;
    local_reload = 1'b0;
    tick();
    fe0 = fe_count;
    rst = 1'b0;
    exp_q.push_back({4'hA, 1'b1, 1'b0});
    k = 0;
    while (remote_connected !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check_output("loop_connect_in_time", (k < 200), 1'b1);
    check_output("loop_connected", remote_connected, 1'b1);
    check_remote("loop");
    repeat (100) tick();
    exp_q.push_back({4'hA, 1'b1, 1'b0});
    check_remote("loop_steady");
    check_output("loop_no_frame_error", fe_count - fe0, 0);

    // Good frame then parity error
    loop_en = 1'b0;
    rx_drv = 1'b1;
    repeat (100) tick();
    d = {4'h3, 1'b0, 1'b1};
    exp_q.push_back(d);
    apply_stimulus(d, ^d, 1'b1, 9 * BC, upd);
    repeat (2) tick();
    check_remote("good1");
    fe0 = fe_count;
    apply_stimulus(6'h15, 1'b0, 1'b1, 9 * BC, upd);
    repeat (3) tick();
    check_output("parity_err_pulses", fe_count - fe0, 1);
    exp_q.push_back(d);
    check_remote("parity_hold");

    // False start glitch
    fe0 = fe_count;
    rx_drv = 1'b0;
    repeat (3) tick();
    rx_drv = 1'b1;
    repeat (12) tick();
    d = {4'h6, 1'b0, 1'b1};
    exp_q.push_back(d);
    apply_stimulus(d, ^d, 1'b1, 9 * BC, upd);
    repeat (2) tick();
    check_remote("after_glitch");
    check_output("glitch_no_frame_error", fe_count - fe0, 0);

    // Timeout
    d = {4'h9, 1'b1, 1'b0};
    exp_q.push_back(d);
    apply_stimulus(d, ^d, 1'b1, 9 * BC, upd);
    check_output("timeout_update_seen", (upd >= 0), 1'b1);
    check_remote("pre_timeout");
    k = 9 * BC - 1 - upd;
    while (remote_connected === 1'b1 && k < 600) begin
      tick();
      k++;
    end
    check_output("timeout_cycles", k, TO);
    check_output("timeout_pause", remote_pause, 1'b0);
    check_output("timeout_score", remote_score, 4'd0);
    check_output("timeout_connected", remote_connected, 1'b0);

    // Reset in the middle of an RX frame
    d = {4'h5, 1'b1, 1'b1};
    exp_q.push_back(d);
    apply_stimulus(d, ^d, 1'b1, 9 * BC, upd);
    tick();
    check_remote("pre_reset");
    check_output("pre_reset_connected", remote_connected, 1'b1);
    apply_stimulus(6'h2A, 1'b1, 1'b1, 4 * BC + 4, upd);
    rst = 1'b1;
    #1;
    check_output("midrst_remote", {remote_score, remote_pause, remote_reload}, 6'd0);
    check_output("midrst_connected", remote_connected, 1'b0);
    check_output("midrst_tx_line", tx_line, 1'b1);
    tick();
    rx_drv = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    d = {4'hC, 1'b0, 1'b1};
    exp_q.push_back(d);
    apply_stimulus(d, ^d, 1'b1, 9 * BC, upd);
    tick();
    check_remote("post_reset");
    check_output("post_reset_connected", remote_connected, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
